// File: rtl/fetch_queue.sv
// fetch_queue: (pc, inst) FIFO between fetch and decode with flush and full back-pressure
// Ports: clk/rst (sync, active-high); flush_i discards all entries; push_i/pc_i/inst_i enqueue
// unless full_o; valid_o/ready_i handshake the head on pc_o/inst_o; count_o is occupancy.
// pc_o/inst_o show 0/NOP_INST whenever the queue is empty so decode only ever sees a bubble.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 64,
  parameter int          INST_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic [INST_W-1:0]          inst_i,
  output logic                       full_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_acc, pop;
  always_comb begin
    full_o   = count_q == CNT_W'(DEPTH);
    valid_o  = count_q != '0;
    count_o  = count_q;
    pc_o     = valid_o ? pc_q[rd_ptr_q] : '0;
    inst_o   = valid_o ? inst_q[rd_ptr_q] : INST_W'(NOP_INST);
    push_acc = push_i && !full_o;
    pop      = valid_o && ready_i;
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + PTR_W'(push_acc);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + PTR_W'(pop);
    count_d  = flush_i ? '0 : count_q + CNT_W'(push_acc) - CNT_W'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Storage is not reset; a write during flush/rst is harmless since occupancy drops to zero.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      pc_q[wr_ptr_q]   <= pc_i;
      inst_q[wr_ptr_q] <= inst_i;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven and directed checks for fetch_queue
module tb_fetch_queue;
  localparam logic [31:0] NOP = 32'h00000013;
  logic        clk = 0, rst = 1, flush_i = 0, push_i = 0, ready_i = 0;
  logic [63:0] pc_i = '0, pc_o;
  logic [31:0] inst_i = '0, inst_o;
  logic        full_o, valid_o;
  logic [2:0]  count_o;
  int          errors = 0, checks = 0;
  fetch_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .push_i(push_i), .pc_i(pc_i), .inst_i(inst_i),
    .full_o(full_o), .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .inst_o(inst_o),
    .count_o(count_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rst, flush, push, ready;
    logic [63:0] pc;
    logic [2:0]  cnt;
    logic        valid, full;
    logic [63:0] pc_o;
  } vec_t;
  vec_t vecs[$];
  logic [63:0] model[$];
  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return 32'hA000_0000 | pc[31:0];
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic drive(input logic r, input logic f, input logic p, input logic rd, input logic [63:0] pc);
    rst = r; flush_i = f; push_i = p; ready_i = rd; pc_i = pc; inst_i = inst_of(pc);
  endtask
  task automatic add(input logic r, f, p, rd, input logic [63:0] pc,
                     input logic [2:0] cnt, input logic v, fu, input logic [63:0] po);
    vec_t e;
    e.rst = r; e.flush = f; e.push = p; e.ready = rd; e.pc = pc;
    e.cnt = cnt; e.valid = v; e.full = fu; e.pc_o = po;
    vecs.push_back(e);
  endtask
  initial begin
    //   rst f p rd  pc       cnt v f  pc_o
    add(1, 0, 0, 0, 64'h0,  0, 0, 0, 64'h0);
    add(0, 0, 1, 0, 64'h0,  1, 1, 0, 64'h0);
    add(0, 0, 1, 0, 64'h4,  2, 1, 0, 64'h0);
    add(0, 0, 1, 0, 64'h8,  3, 1, 0, 64'h0);
    add(0, 0, 1, 0, 64'hC,  4, 1, 1, 64'h0);
    add(0, 0, 1, 0, 64'h10, 4, 1, 1, 64'h0);
    add(0, 0, 1, 1, 64'h14, 3, 1, 0, 64'h4);
    add(0, 0, 0, 1, 64'h0,  2, 1, 0, 64'h8);
    add(0, 0, 0, 1, 64'h0,  1, 1, 0, 64'hC);
    add(0, 0, 0, 1, 64'h0,  0, 0, 0, 64'h0);
    add(0, 0, 0, 1, 64'h0,  0, 0, 0, 64'h0);
    add(0, 0, 1, 0, 64'h20, 1, 1, 0, 64'h20);
    add(0, 0, 1, 0, 64'h24, 2, 1, 0, 64'h20);
    add(0, 0, 1, 0, 64'h28, 3, 1, 0, 64'h20);
    add(0, 1, 1, 1, 64'h40, 0, 0, 0, 64'h0);
    add(0, 0, 0, 0, 64'h0,  0, 0, 0, 64'h0);
    add(0, 0, 1, 0, 64'h44, 1, 1, 0, 64'h44);
    add(0, 0, 1, 0, 64'h50, 2, 1, 0, 64'h44);
    add(0, 1, 1, 0, 64'h60, 2, 1, 0, 64'h44);
    add(1, 1, 1, 1, 64'h60, 0, 0, 0, 64'h0);
    add(0, 0, 0, 0, 64'h0,  0, 0, 0, 64'h0);
    vecs[18].rst = 1;
    vecs[18].cnt = 0; vecs[18].valid = 0; vecs[18].pc_o = 64'h0;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].push, vecs[i].ready, vecs[i].pc);
      @(posedge clk); #1;
      chk($sformatf("v%0d count", i), 64'(count_o), 64'(vecs[i].cnt));
      chk($sformatf("v%0d valid", i), 64'(valid_o), 64'(vecs[i].valid));
      chk($sformatf("v%0d full", i),  64'(full_o),  64'(vecs[i].full));
      chk($sformatf("v%0d pc", i),    pc_o, vecs[i].pc_o);
      chk($sformatf("v%0d inst", i),  64'(inst_o),
          64'(vecs[i].valid ? inst_of(vecs[i].pc_o) : NOP));
    end
    drive(0, 0, 1, 1, 64'h80);
    #1;
    chk("nobypass valid", 64'(valid_o), 64'(0));
    chk("nobypass inst", 64'(inst_o), 64'(NOP));
    @(posedge clk); #1;
    chk("push80 valid", 64'(valid_o), 64'(1));
    chk("push80 pc", pc_o, 64'h80);
    chk("push80 count", 64'(count_o), 64'(1));
    drive(0, 0, 1, 0, 64'h84);
    @(posedge clk); #1;
    model.push_back(64'h80);
    model.push_back(64'h84);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("stream%0d pc", i), pc_o, model[0]);
      chk($sformatf("stream%0d inst", i), 64'(inst_o), 64'(inst_of(model[0])));
      drive(0, 0, 1, 1, 64'h100 + 64'(4 * i));
      @(posedge clk); #1;
      void'(model.pop_front());
      model.push_back(64'h100 + 64'(4 * i));
      chk($sformatf("stream%0d count", i), 64'(count_o), 64'(2));
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("drain%0d pc", i), pc_o, model[0]);
      drive(0, 0, 0, 1, 64'h0);
      @(posedge clk); #1;
      void'(model.pop_front());
    end
    chk("drain empty valid", 64'(valid_o), 64'(0));
    chk("drain empty pc", pc_o, 64'h0);
    chk("drain empty count", 64'(count_o), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
